// File: rtl/window_line_buffer.sv
// Rotating K+1 line buffer that turns a raster pixel stream into KxK windows.
// One line buffer is retired after each line's IMG_W-K+1 windows are handed off.

module window_row #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [DATA_W-1:0]   col_in,
  output logic [K*DATA_W-1:0] row_out
);
  // taps[0] is the leftmost (oldest) column; new columns enter at taps[K-1]
  logic [K-1:0][DATA_W-1:0] taps;

  always_ff @(posedge clk or posedge reset)
    if (reset)         taps <= '0;
    else if (shift_en) taps <= {col_in, taps[K-1:1]};

  assign row_out = taps;
endmodule

module window_line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 128,
  parameter int K      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       in_pixel_data,
  input  logic                    in_pixel_data_valid,
  output logic                    in_ready,
  output logic [K*K*DATA_W-1:0]   out_window_data,
  output logic                    out_window_valid,
  input  logic                    out_ready,
  output logic                    line_done,
  output logic [$clog2(K+2)-1:0]  lines_filled
);
  localparam int NBUF  = K + 1;
  localparam int BUF_W = $clog2(NBUF);
  localparam int COL_W = $clog2(IMG_W);
  localparam int LF_W  = $clog2(NBUF + 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0]        mem [NBUF][IMG_W];
  logic [BUF_W-1:0]         wr_buf, rd_buf;
  logic [COL_W-1:0]         wr_col, rd_col;
  logic [K-1:0][DATA_W-1:0] col_in;

  logic wr_en, wr_last, slot_free;
  logic start, shift_en, load_valid, retire;

  assign in_ready  = lines_filled < LF_W'(NBUF);
  assign wr_en     = in_pixel_data_valid && in_ready;
  assign wr_last   = wr_en && (wr_col == COL_W'(IMG_W - 1));
  assign slot_free = !out_window_valid || out_ready;

  // ---- write side ----
  always_ff @(posedge clk)
    if (wr_en) mem[wr_buf][wr_col] <= in_pixel_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_col <= '0;
      wr_buf <= '0;
    end else if (wr_en) begin
      if (wr_last) begin
        wr_col <= '0;
        wr_buf <= (wr_buf == BUF_W'(NBUF - 1)) ? '0 : wr_buf + BUF_W'(1);
      end else begin
        wr_col <= wr_col + COL_W'(1);
      end
    end

  // ---- read FSM ----
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (lines_filled >= LF_W'(K))                       state_nx = PRIME;
      PRIME:  if (rd_col == COL_W'(K - 2))                        state_nx = STREAM;
      STREAM: if (slot_free && rd_col == COL_W'(IMG_W - 1))       state_nx = DRAIN;
      DRAIN:  if (out_window_valid && out_ready)                  state_nx = IDLE;
      default:                                                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    shift_en   = 1'b0;
    load_valid = 1'b0;
    retire     = 1'b0;
    unique case (state)
      IDLE:   start = lines_filled >= LF_W'(K);
      PRIME:  shift_en = 1'b1;
      STREAM: begin
        shift_en   = slot_free;
        load_valid = slot_free;
      end
      DRAIN:  retire = out_window_valid && out_ready;
      default: ;
    endcase
  end

  // ---- read datapath ----
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_col           <= '0;
      rd_buf           <= '0;
      out_window_valid <= 1'b0;
      line_done        <= 1'b0;
    end else begin
      line_done <= retire;
      if (start)         rd_col <= '0;
      else if (shift_en) rd_col <= rd_col + COL_W'(1);
      if (retire) begin
        out_window_valid <= 1'b0;
        rd_buf           <= (rd_buf == BUF_W'(NBUF - 1)) ? '0 : rd_buf + BUF_W'(1);
      end else if (load_valid) begin
        out_window_valid <= 1'b1;
      end
    end

  // A line completing on the same edge a buffer retires leaves the count unchanged
  always_ff @(posedge clk or posedge reset)
    if (reset) lines_filled <= '0;
    else begin
      unique case ({wr_last, retire})
        2'b10:   lines_filled <= lines_filled + LF_W'(1);
        2'b01:   lines_filled <= lines_filled - LF_W'(1);
        default: lines_filled <= lines_filled;
      endcase
    end

  // ---- window rows: row r reads buffer (rd_buf + r) mod NBUF ----
  for (genvar r = 0; r < K; r++) begin : g_row
    logic [BUF_W:0]   sum;
    logic [BUF_W-1:0] idx;

    always_comb begin
      sum = {1'b0, rd_buf} + (BUF_W+1)'(r);
      idx = (sum >= (BUF_W+1)'(NBUF)) ? BUF_W'(sum - (BUF_W+1)'(NBUF)) : BUF_W'(sum);
    end

    assign col_in[r] = mem[idx][rd_col];

    window_row #(.DATA_W(DATA_W), .K(K)) u_row (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .col_in   (col_in[r]),
      .row_out  (out_window_data[r*K*DATA_W +: K*DATA_W])
    );
  end
endmodule

// File: doc/window_line_buffer.md
# window_line_buffer

Parametrised line-buffer controller for the image filter path. It accepts a raster pixel stream one pixel per beat into a rotating set of K+1 line buffers. Once K complete lines are held, it emits K×K pixel windows with a valid/ready handshake, which the convolution/filter stage consumes. It replaces the fixed 3-line, 8-bit controller and adds kernel-size, width and backpressure generality.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 128, pixels per line (IMG_W ≥ K)
- K, 3, window height and width (K ≥ 2); buffer count NBUF = K+1
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all control state
- in_pixel_data  input  DATA_W  incoming pixel, raster order
- in_pixel_data_valid  input  1  pixel present this cycle
- in_ready  output  1  block can accept a pixel this cycle
- out_window_data  output  K*K*DATA_W  window; element (r,c) at [((r*K)+c)*DATA_W +: DATA_W], r=0 oldest line, c=0 leftmost column
- out_window_valid  output  1  window present
- out_ready  input  1  consumer accepts window
- line_done  output  1  one-cycle pulse when a line buffer is retired
- lines_filled  output  clog2(NBUF+1)  count of complete, unretired lines

## Operation
- Storage: NBUF register arrays of IMG_W×DATA_W, asynchronous (combinational) read, synchronous write. Contents are not cleared by reset.
- Write side: a write occurs when in_pixel_data_valid && in_ready. It stores to buffer wr_buf at column wr_col, then wr_col++.
  - On the write at wr_col = IMG_W-1: wr_col → 0, wr_buf → (wr_buf+1) mod NBUF, lines_filled++.
- in_ready = (lines_filled < NBUF). The buffer being written is never among the K being read.
- Read side: the K rows of a window come from buffers rd_buf, rd_buf+1, …, rd_buf+K-1 (mod NBUF). K shift registers, each K deep, hold the window columns.
- State machine:
  - IDLE: when lines_filled ≥ K, clear rd_col and go to PRIME.
  - PRIME: each cycle shift column rd_col of all K rows into the window registers and increment rd_col. After K-1 loads, go to STREAM.
  - STREAM: when the output slot is free (!out_window_valid || out_ready), shift column rd_col, set out_window_valid, increment rd_col. When the column loaded is IMG_W-1, go to DRAIN.
    - If the slot is not free, hold.
  - DRAIN: on out_window_valid && out_ready, clear out_window_valid, rd_buf → (rd_buf+1) mod NBUF, lines_filled--, pulse line_done the next cycle, go to IDLE.
- Each line produces IMG_W-K+1 windows, then retires exactly one buffer.
- Simultaneous line-complete write and retire in the same cycle: lines_filled is unchanged.
- out_window_data and out_window_valid are stable while out_window_valid && !out_ready.
- The stream is continuous; there is no frame boundary logic. Line count wraps freely mod NBUF.

## Timing
- Reset values: in_ready=1, out_window_valid=0, out_window_data=0, line_done=0, lines_filled=0, state IDLE, all pointers 0.
- Reset asserted mid-operation aborts immediately. Partially written lines and pending windows are discarded.
- Latency: the last pixel of line K-1 is written at edge N. Then:
  - lines_filled=K after edge N.
  - PRIME entered at N+1.
  - out_window_valid first high after edge N+K+1; for K=3 this is after edge N+4.
- With out_ready held high: one window per cycle, IMG_W-K+1 consecutive cycles.
- DRAIN adds one cycle after the last handshake. IDLE adds one cycle before re-priming.
- line_done is high for exactly one cycle, the cycle after the final window handshake of the line.
- in_ready falls in the cycle after the write that makes lines_filled = NBUF. It rises in the cycle after the retire.

## Test plan
- K=3, IMG_W=8, DATA_W=8, out_ready=1; feed pixel=row*16+col for rows 0–2 -> first window 4 cycles after the last pixel, holding {00,01,02,10,11,12,20,21,22}; 6 windows, last {05,06,07,15,16,17,25,26,27}; line_done pulse after the 6th.
- Same stream, out_ready toggled pseudo-randomly -> window data stable while stalled; the 6 windows arrive in order, none lost or duplicated.
- out_ready=0, stream continuously -> after the last pixel of row 3, lines_filled=4 and in_ready=0; pixels offered while in_ready=0 are not written; raising out_ready resumes flow with correct rows 1–3 in the next line's windows.
- Arrange for the row-4 last-pixel write and the DRAIN handshake to fall on the same edge -> lines_filled stays at 3, line_done pulses, wr_buf and rd_buf both advance.
- Stream 10 rows with out_ready=1 -> buffer indices wrap mod 4; final line's first window = {70,71,72,80,81,82,90,91,92}; 8 line_done pulses in total.
- Assert reset mid-row-2 for 1 cycle, then restart from row 0 -> all outputs at reset values; first window again {00,…,22} at the specified latency.
